// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : fetch controller states
//   PC_INCR       : byte distance between sequential instructions
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle, // nothing outstanding, hold buffer empty
        StWait, // one request outstanding
        StHold, // hold buffer full, nothing outstanding
        StKill  // one wrong-path request outstanding, response will be dropped
    } fetch_state_t;

    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the fetch PC and keeps at most one request in flight to instruction memory.
// A 1-entry hold buffer absorbs downstream stalls. An EX redirect squashes wrong-path fetches.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall             : downstream not accepting this cycle
//   redirect          : taken branch/jump from EX
//   redirect_pc       : redirect target
//   imem_req          : fetch request valid
//   imem_addr         : fetch address (always the current fetch PC)
//   imem_ready        : memory accepts the request this cycle
//   imem_rvalid       : in-order response valid
//   imem_rdata        : response instruction
//   ins_valid         : ins_out/pc_out/pc_plus4_out carry a real instruction
//   ins_out           : fetched instruction (0 when not valid)
//   pc_out            : its address (0 when not valid)
//   pc_plus4_out      : pc_out + 4 with wrap (0 when not valid)
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  ins_valid,
    output logic [DATA_WIDTH-1:0] ins_out,
    output logic [PC_WIDTH-1:0]   pc_out,
    output logic [PC_WIDTH-1:0]   pc_plus4_out
);

    localparam logic [PC_WIDTH-1:0] Incr = PC_WIDTH'(PC_INCR);

    fetch_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]   req_pc_q;
    logic [PC_WIDTH-1:0]   hold_pc_q;
    logic [DATA_WIDTH-1:0] hold_ins_q;
    logic                  outstanding_q, outstanding_d;

    logic accept;
    logic capture;
    logic from_hold;

    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req & imem_ready;

    // Handshake outputs; redirect and reset suppress both request and delivery.
    always_comb begin
        imem_req  = 1'b0;
        ins_valid = 1'b0;
        from_hold = 1'b0;
        unique case (state_q)
            StIdle: imem_req = 1'b1;
            StWait: begin
                // Issue the next request in the same cycle the response is taken,
                // which keeps the stream at one instruction per cycle.
                imem_req  = imem_rvalid & ~stall;
                ins_valid = imem_rvalid;
            end
            StHold: begin
                imem_req  = ~stall;
                ins_valid = 1'b1;
                from_hold = 1'b1;
            end
            StKill: begin
                imem_req  = 1'b0;
                ins_valid = 1'b0;
            end
            default: begin
                imem_req  = 1'b0;
                ins_valid = 1'b0;
            end
        endcase
        if (rst || redirect) begin
            imem_req  = 1'b0;
            ins_valid = 1'b0;
        end
    end

    // Data outputs are zeroed whenever nothing valid is presented.
    always_comb begin
        ins_out      = '0;
        pc_out       = '0;
        pc_plus4_out = '0;
        if (ins_valid) begin
            ins_out      = from_hold ? hold_ins_q : imem_rdata;
            pc_out       = from_hold ? hold_pc_q : req_pc_q;
            pc_plus4_out = pc_out + Incr;
        end
    end

    // Tracks whether memory still owes a response after this cycle, independent of
    // the FSM, so a reset or redirect knows whether a stale response is on its way.
    assign outstanding_d = accept | (outstanding_q & ~imem_rvalid);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StWait;
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (stall) begin
                        state_d = StHold;
                        capture = 1'b1;
                    end else begin
                        state_d = accept ? StWait : StIdle;
                    end
                end
            end
            StHold: begin
                if (!stall) state_d = accept ? StWait : StIdle;
            end
            StKill: begin
                if (imem_rvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Redirect drops the buffer; a response still owed is squashed in StKill.
        if (redirect) begin
            state_d = outstanding_d ? StKill : StIdle;
            capture = 1'b0;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + Incr;
        end
    end

    // outstanding_q is intentionally outside the reset so a response that was in
    // flight when reset hit is still recognised and discarded afterwards.
    always_ff @(posedge clk) begin
        outstanding_q <= outstanding_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= outstanding_d ? StKill : StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            hold_pc_q  <= '0;
            hold_ins_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (accept) begin
                req_pc_q <= fetch_pc_q;
            end
            if (capture) begin
                hold_ins_q <= imem_rdata;
                hold_pc_q  <= req_pc_q;
            end
        end
    end

endmodule
